// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared definitions for the RV32 core slice. The decoder, writeback mux
//   and load/store unit all import this package so that the size codes,
//   writeback source selects and ALU operation codes have one definition.
//   No ports (package).
package rv32_pkg;

    // Access size carried in ram_req[1:0]
    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_X = 2'b11;

    localparam int unsigned LSU_DATA_W = 32;

    // Load/store unit control states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_t;

    // Writeback source selects
    localparam logic [1:0] WB_SOURCE_ALU = 2'b00;
    localparam logic [1:0] WB_SOURCE_LSU = 2'b01;
    localparam logic [1:0] WB_SOURCE_PC4 = 2'b10;
    localparam logic [1:0] WB_SOURCE_IMM = 2'b11;

    // ALU operation codes
    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'h1;
    localparam logic [3:0] ALU_OP_SLL  = 4'h2;
    localparam logic [3:0] ALU_OP_SLT  = 4'h3;
    localparam logic [3:0] ALU_OP_SLTU = 4'h4;
    localparam logic [3:0] ALU_OP_XOR  = 4'h5;
    localparam logic [3:0] ALU_OP_SRL  = 4'h6;
    localparam logic [3:0] ALU_OP_SRA  = 4'h7;
    localparam logic [3:0] ALU_OP_OR   = 4'h8;
    localparam logic [3:0] ALU_OP_AND  = 4'h9;

    // An access is rejected when its size code is illegal or when it does
    // not sit on its natural boundary (halves on even bytes, words on
    // multiples of four).
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = addr_lo[0];
            LSU_SIZE_W: bad = |addr_lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rv32_mod_lsu_align.sv
// rv32_mod_lsu_align
//   Purely combinational data-path helper for the load/store unit.
//   Ports:
//     size          in  2   access size code
//     load_unsigned in  1   zero-extend loads when set
//     addr_lo       in  2   byte offset within the word
//     wdata         in  32  LSB-justified store data
//     rdata         in  32  raw word returned by the bus
//     be            out 4   byte enables for the access
//     lane_wdata    out 32  store data replicated into every lane
//     load_data     out 32  shifted and extended load result
//     misaligned    out 1   illegal size or off-boundary access
module rv32_mod_lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Byte enables and lane replication. Replicating the store data into
    // every lane lets the bus pick up the right bytes using only the byte
    // enables, no matter which offset was addressed.
    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        case (size)
            LSU_SIZE_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                be         = 4'b0011 << addr_lo;
                lane_wdata = {2{wdata[15:0]}};
            end
            LSU_SIZE_W: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = 32'h0;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend it to 32
    // bits according to the access size and signedness.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = 32'h0;
        case (size)
            LSU_SIZE_B: begin
                if (load_unsigned)
                    load_data = {24'h0, shifted[7:0]};
                else
                    load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_SIZE_H: begin
                if (load_unsigned)
                    load_data = {16'h0, shifted[15:0]};
                else
                    load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            LSU_SIZE_W: load_data = shifted;
            default:    load_data = 32'h0;
        endcase
    end

    assign misaligned = lsu_misaligned(size, addr_lo);

endmodule

// File: rtl/rv32_mod_load_store_unit.sv
// rv32_mod_load_store_unit
//   Runs one load or store at a time on the data-memory bus and returns
//   aligned, extended load data to writeback. The core stalls while
//   req_ready is low.
//   Ports:
//     clk, rstn                 clock (rising edge), async active-low reset
//     req_valid / req_ready     operation handshake from execute
//     ram_req[3:0]              [1:0] size, [2] unsigned load, [3] unused
//     ram_wr                    1 store, 0 load
//     addr, wdata               byte address and LSB-justified store data
//     rsp_valid                 one-cycle completion pulse
//     rsp_rdata                 extended load data (0 for stores/errors)
//     rsp_err, rsp_misaligned   error flags qualified by rsp_valid
//     mem_req/mem_wr/mem_addr/mem_be/mem_wdata   bus request, held to ack
//     mem_ack/mem_rdata/mem_err                  bus completion
module rv32_mod_load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        ram_req,
    input  logic              ram_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_err
);

    lsu_state_t  state;
    logic [31:0] timer;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_addr_lo;

    logic [1:0]  align_size;
    logic        align_unsigned;
    logic [1:0]  align_addr_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misaligned;
    logic        timed_out;
    logic        unused_reserved;

    // The reserved request bit is deliberately ignored.
    assign unused_reserved = ram_req[3];

    // While idle the aligner looks at the incoming request so the bus
    // fields can be registered on the accepting edge; once busy it looks
    // at the latched operation so the returning read data is extended
    // with the right size and offset.
    assign align_size     = (state == LSU_IDLE) ? ram_req[1:0] : lat_size;
    assign align_unsigned = (state == LSU_IDLE) ? ram_req[2]   : lat_unsigned;
    assign align_addr_lo  = (state == LSU_IDLE) ? addr[1:0]    : lat_addr_lo;

    rv32_mod_lsu_align u_align (
        .size          (align_size),
        .load_unsigned (align_unsigned),
        .addr_lo       (align_addr_lo),
        .wdata         (wdata),
        .rdata         (mem_rdata),
        .be            (align_be),
        .lane_wdata    (align_wdata),
        .load_data     (align_load),
        .misaligned    (align_misaligned)
    );

    // The timer counts BUS cycles that ended without an ack; when the
    // last allowed cycle also ends without one, the access is abandoned.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES - 1);

    // Single control process: every output is registered here so the bus
    // and response signals change only on clock edges (or on reset, which
    // drops mem_req immediately and discards any pending response).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= LSU_IDLE;
            req_ready      <= 1'b1;
            timer          <= 32'h0;
            lat_size       <= 2'b00;
            lat_unsigned   <= 1'b0;
            lat_addr_lo    <= 2'b00;
            mem_req        <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'b0000;
            mem_wdata      <= 32'h0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
            rsp_misaligned <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        lat_size     <= ram_req[1:0];
                        lat_unsigned <= ram_req[2];
                        lat_addr_lo  <= addr[1:0];
                        req_ready    <= 1'b0;
                        if (align_misaligned) begin
                            // Rejected without touching the bus.
                            state          <= LSU_RESP;
                            rsp_valid      <= 1'b1;
                            rsp_err        <= 1'b1;
                            rsp_misaligned <= 1'b1;
                            rsp_rdata      <= 32'h0;
                        end else begin
                            state     <= LSU_BUS;
                            timer     <= 32'h0;
                            mem_req   <= 1'b1;
                            mem_wr    <= ram_wr;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= align_be;
                            mem_wdata <= align_wdata;
                        end
                    end
                end

                LSU_BUS: begin
                    if (mem_ack || timed_out) begin
                        state          <= LSU_RESP;
                        mem_req        <= 1'b0;
                        mem_wr         <= 1'b0;
                        mem_addr       <= '0;
                        mem_be         <= 4'b0000;
                        mem_wdata      <= 32'h0;
                        rsp_valid      <= 1'b1;
                        rsp_misaligned <= 1'b0;
                        // Ack wins over a timeout landing on the same edge.
                        if (mem_ack) begin
                            rsp_err   <= mem_err;
                            rsp_rdata <= (mem_err || mem_wr) ? 32'h0 : align_load;
                        end else begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                LSU_RESP: begin
                    state          <= LSU_IDLE;
                    req_ready      <= 1'b1;
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= 32'h0;
                    rsp_err        <= 1'b0;
                    rsp_misaligned <= 1'b0;
                end

                default: begin
                    state     <= LSU_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// tb_rv32_mod_load_store_unit
//   Self-checking bench for the load/store unit. Directed cases from the
//   feature list are followed by randomized operations; every expected
//   value comes from a small arithmetic reference model below.
module tb_rv32_mod_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  ram_req;
    logic        ram_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_misaligned;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_passed = 0;

    rv32_mod_load_store_unit #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (32)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .ram_req        (ram_req),
        .ram_wr         (ram_wr),
        .addr           (addr),
        .wdata          (wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .rsp_misaligned (rsp_misaligned),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_passed++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model: plain arithmetic over the access rules.
    function automatic bit ref_bad(input int sz, input int off);
        if (sz == 3) return 1'b1;
        if (sz == 1) return (off % 2) != 0;
        if (sz == 2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_be(input int sz, input int off);
        if (sz == 0) return 32'(1 << off);
        if (sz == 1) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] wd);
        if (sz == 0) return 32'(longint'(wd % 256) * 64'h0101_0101);
        if (sz == 1) return 32'(longint'(wd % 65536) * 64'h0001_0001);
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input int sz, input bit uns,
                                             input int off, input logic [31:0] word);
        longint v;
        v = longint'(word) / (longint'(1) << (8 * off));
        if (sz == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    // Run one operation from IDLE and check the bus side and response.
    // Enters and leaves 1 time unit after a rising edge with the unit idle.
    task automatic applyStimulus(input int sz, input bit uns, input bit rsv,
                                 input bit wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int waits, input bit berr,
                                 input bit noack, input bit hold);
        int          off;
        int          n_cycles;
        logic [31:0] exp_rdata;
        off = int'(a % 4);
        req_valid = 1'b1;
        ram_req   = {rsv, uns, 2'(sz)};
        ram_wr    = wr;
        addr      = a;
        wdata     = wd;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (hold) begin
            addr  = a ^ 32'h0000_0110;
            wdata = ~wd;
        end else begin
            req_valid = 1'b0;
        end

        if (ref_bad(sz, off)) begin
            req_valid = 1'b0;
            checkOutput("mis_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("mis_rsp_err", 32'(rsp_err), 32'd1);
            checkOutput("mis_rsp_flag", 32'(rsp_misaligned), 32'd1);
            checkOutput("mis_rsp_rdata", rsp_rdata, 32'h0);
            checkOutput("mis_no_mem_req", 32'(mem_req), 32'd0);
            checkOutput("mis_req_ready", 32'(req_ready), 32'd0);
        end else begin
            n_cycles = noack ? int'(TMO) : waits + 1;
            for (int i = 0; i < n_cycles; i++) begin
                checkOutput("bus_mem_req", 32'(mem_req), 32'd1);
                checkOutput("bus_mem_addr", mem_addr, a - 32'(off));
                checkOutput("bus_mem_be", 32'(mem_be), ref_be(sz, off));
                checkOutput("bus_mem_wr", 32'(mem_wr), 32'(wr));
                checkOutput("bus_mem_wdata", mem_wdata, ref_wdata(sz, wd));
                checkOutput("bus_rsp_valid", 32'(rsp_valid), 32'd0);
                checkOutput("bus_req_ready", 32'(req_ready), 32'd0);
                mem_rdata = rd;
                mem_err   = berr;
                mem_ack   = (!noack && i == waits);
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_err   = 1'b0;
            end
            req_valid = 1'b0;
            if (noack || berr || wr) exp_rdata = 32'h0;
            else exp_rdata = ref_load(sz, uns, off, rd);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_err", 32'(rsp_err), 32'(noack || berr));
            checkOutput("rsp_misaligned", 32'(rsp_misaligned), 32'd0);
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("rsp_mem_req_low", 32'(mem_req), 32'd0);
        end

        @(posedge clk); #1;
        checkOutput("after_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("after_req_ready", 32'(req_ready), 32'd1);
        checkOutput("after_mem_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        int          sz;
        int          waits;
        bit          noack;
        logic [31:0] a;

        rstn      = 1'b0;
        req_valid = 1'b0;
        ram_req   = 4'h0;
        ram_wr    = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        mem_err   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Signed and unsigned byte loads from the top lane
        applyStimulus(0, 0, 0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
        // Half store with three wait states, request held during BUS
        applyStimulus(1, 0, 0, 1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3, 0, 0, 1);
        // Misaligned word and illegal size
        applyStimulus(2, 0, 0, 0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(3, 0, 1, 0, 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0, 0);
        // Bus error on a word load
        applyStimulus(2, 0, 0, 0, 32'h0000_4000, 32'h0, 32'h1234_5678, 0, 1, 0, 0);
        // Timeout, then a late ack that must be ignored
        applyStimulus(2, 0, 0, 0, 32'h0000_5000, 32'h0, 32'hAAAA_5555, 0, 0, 1, 0);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("late_ack_mem_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a bus cycle
        req_valid = 1'b1;
        ram_req   = 4'b0010;
        ram_wr    = 1'b0;
        addr      = 32'h0000_6000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("async_reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 1, 0, 0, 0);

        // Randomized operations
        for (int n = 0; n < 150; n++) begin
            sz = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) a = a & 32'hFFFF_FFFE;
                if (sz >= 2) a = a & 32'hFFFF_FFFC;
            end
            waits = int'($urandom_range(0, TMO - 1));
            noack = ($urandom_range(0, 19) == 0);
            applyStimulus(sz, 1'($urandom), 1'($urandom), 1'($urandom), a,
                          $urandom, $urandom, waits,
                          ($urandom_range(0, 7) == 0), noack,
                          ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_mod_load_store_unit.md
Name: rv32_mod_load_store_unit

Overview:
Executes the memory operations that the instruction decoder requests through `ram_req` / `ram_wr`.
- Takes the ALU-computed address and the rs2 store data from execute.
- Runs one transaction on the data-memory bus with byte enables.
- Returns aligned, sign- or zero-extended load data to writeback, which selects it when `wb_source` is LSU.
- Sits between execute/writeback and the data bus. Handles one operation at a time; the core stalls while the unit is busy.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed while waiting for `mem_ack` before the unit aborts with an error; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  execute presents a memory operation
- req_ready  out  1  unit can accept an operation (IDLE only)
- ram_req  in  4  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned load; [3] reserved, ignored
- ram_wr  in  1  1 store, 0 load
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  store data (rs2), LSB-justified
- rsp_valid  out  1  one-cycle pulse: operation finished
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  1  qualified by `rsp_valid`: misaligned, illegal size, bus error or timeout
- rsp_misaligned  out  1  qualified by `rsp_valid`: the error was misalignment or illegal size
- mem_req  out  1  bus request, held until `mem_ack`
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data replicated into the byte lanes
- mem_ack  in  1  bus completes the current request this cycle
- mem_rdata  in  32  read data, valid with `mem_ack`
- mem_err  in  1  bus error, valid with `mem_ack`

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE, `req_ready`=1. All other outputs 0, including `mem_req`, `mem_be`, `rsp_valid` and the timeout counter. Reset mid-transaction drops `mem_req` immediately and emits no response.
- States: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. On `req_valid` at edge N, latch the operation.
  - If size=11, or it is a misaligned half (addr[0]≠0) or word (addr[1:0]≠0): go to RESP with err=1 and misaligned=1. No bus cycle.
  - Otherwise go to BUS and drive `mem_*` from N+1.
- Byte enables:
  - byte: be = 0001 << addr[1:0]
  - half: be = 0011 << addr[1:0]
  - word: be = 1111
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- BUS:
  - `mem_req`=1 and `mem_addr`/`mem_be`/`mem_wr`/`mem_wdata` are held stable until the edge where `mem_ack`=1.
  - On ack: capture `mem_rdata` shifted right by 8*addr[1:0], extend per size and ram_req[2], latch `mem_err`, go to RESP.
  - `mem_req` deasserts in the cycle after ack.
  - The counter increments each BUS cycle without ack. On reaching TIMEOUT_CYCLES (when nonzero): go to RESP with err=1, drop `mem_req`, ignore any late ack.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 in BUS and RESP.
- Latency: a zero-wait-state bus (ack in the first BUS cycle) gives `rsp_valid` at N+2. A misaligned or illegal operation gives `rsp_valid` at N+1.
- Load extension:
  - signed byte sign-extends from bit 7; signed half from bit 15.
  - unsigned zero-extends.
  - word is passed through.
- Store response: `rsp_rdata`=0.
- On any error: `rsp_rdata`=0.
- `mem_err` with ack: `rsp_err`=1, `rsp_misaligned`=0.
- `req_valid` in a non-IDLE state is ignored (not latched).
- ram_req[3] has no effect.

Decomposition:
- Shared package `rv32_pkg`:
  - size encodings LSU_SIZE_B/H/W
  - `lsu_state_t` enum (IDLE/BUS/RESP)
  - WB_SOURCE_* and ALU_OP_* constants, so the decoder and this unit share one definition
- One combinational sub-module, `rv32_mod_lsu_align`:
  - byte-enable generation
  - store lane replication
  - load shift and extension
  - misalignment detection
- The FSM, counter and latches stay in the top module.

Test Plan:
- Load byte signed, addr=0x1003, mem_rdata=0x80FF_1234, zero-wait ack → `mem_be`=1000 and `mem_addr`=0x1000 at N+1; `rsp_valid` at N+2 with `rsp_rdata`=0xFFFF_FF80, err=0. The same with ram_req[2]=1 → 0x0000_0080.
- Store half, addr=0x2002, wdata=0xDEAD_BEEF, 3 wait states → `mem_wdata`=0xBEEF_BEEF, `mem_be`=1100, `mem_wr`=1, held stable for 4 cycles; `rsp_valid` 1 cycle after ack with rdata=0.
- Load word at addr=0x3001 → no `mem_req` ever; `rsp_valid` at N+1 with `rsp_err`=1 and `rsp_misaligned`=1. Repeat with size=11 at an aligned address → same response.
- Bus error: load word at 0x4000, ack with `mem_err`=1 → `rsp_err`=1, `rsp_misaligned`=0, rdata=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack → `mem_req` high 4 cycles then low; `rsp_err`=1; a late ack 2 cycles afterwards does not produce a second `rsp_valid`.
- Reset mid-BUS: rstn low asynchronously → `mem_req` falls without waiting for clk; after release `req_ready`=1 and a fresh load completes normally. A `req_valid` held during BUS is not accepted twice.
